// File: rtl/fp_lnorm16.sv
`default_nettype none
// ============================================================================
// Module      : fp_lnorm16
// Description : Multi-cycle left normaliser for 16-bit mantissas. Applies a
//               log shifter (8,4,2,1) one stage per cycle, shifting until
//               bit 15 is set or the biased exponent reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_lnorm16 #(
    parameter int EXP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      man_in,
    input  logic [EXP_W-1:0] exp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      man_out,
    output logic [EXP_W-1:0] exp_out,
    output logic [3:0]       shamt_out,
    output logic             zero_out,
    output logic             denorm_out
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S8   = 3'd1;
    localparam logic [2:0] ST_S4   = 3'd2;
    localparam logic [2:0] ST_S2   = 3'd3;
    localparam logic [2:0] ST_S1   = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    logic [2:0]       state;
    logic [15:0]      man_q;
    logic [EXP_W-1:0] exp_q;
    logic [3:0]       shamt_q;
    logic             zero_q;

    logic [3:0]       amt;
    logic [15:0]      top_mask;
    logic             do_shift;
    logic [15:0]      man_nxt;
    logic [EXP_W-1:0] exp_nxt;
    logic [3:0]       shamt_nxt;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Current stage's shift: taken only if the top bits it would discard are
    // zero and the exponent can absorb it without underflow.
    always_comb begin
        amt = 4'd0;
        case (state)
            ST_S8:   amt = 4'd8;
            ST_S4:   amt = 4'd4;
            ST_S2:   amt = 4'd2;
            ST_S1:   amt = 4'd1;
            default: amt = 4'd0;
        endcase
        top_mask  = ~(16'hFFFF >> amt);
        do_shift  = (amt != 4'd0) && ((man_q & top_mask) == 16'h0000)
                    && (exp_q >= EXP_W'(amt));
        man_nxt   = do_shift ? (man_q << amt) : man_q;
        exp_nxt   = do_shift ? (exp_q - EXP_W'(amt)) : exp_q;
        shamt_nxt = do_shift ? (shamt_q + amt) : shamt_q;
    end

    // Sequencer: accept, walk the four shift stages, then hold the result
    // until the downstream handshake completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            man_q      <= 16'h0000;
            exp_q      <= '0;
            shamt_q    <= 4'd0;
            zero_q     <= 1'b0;
            man_out    <= 16'h0000;
            exp_out    <= '0;
            shamt_out  <= 4'd0;
            zero_out   <= 1'b0;
            denorm_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        man_q   <= man_in;
                        exp_q   <= exp_in;
                        shamt_q <= 4'd0;
                        zero_q  <= (man_in == 16'h0000);
                        state   <= ST_S8;
                    end
                end
                ST_S8, ST_S4, ST_S2: begin
                    man_q   <= man_nxt;
                    exp_q   <= exp_nxt;
                    shamt_q <= shamt_nxt;
                    state   <= state + 3'd1;
                end
                ST_S1: begin
                    man_q   <= man_nxt;
                    exp_q   <= exp_nxt;
                    shamt_q <= shamt_nxt;
                    state   <= ST_DONE;
                    if (zero_q) begin
                        // Zero input keeps fixed latency but reports a clean zero.
                        man_out    <= 16'h0000;
                        exp_out    <= '0;
                        shamt_out  <= 4'd0;
                        zero_out   <= 1'b1;
                        denorm_out <= 1'b0;
                    end else begin
                        man_out    <= man_nxt;
                        exp_out    <= exp_nxt;
                        shamt_out  <= shamt_nxt;
                        zero_out   <= 1'b0;
                        denorm_out <= ~man_nxt[15];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_lnorm16.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_lnorm16
// Description : Scoreboard bench for fp_lnorm16 (reset, spec vectors,
//               backpressure, mid-operation reset, random back-to-back).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_lnorm16;

    typedef struct packed {
        logic [15:0] man;
        logic [4:0]  e;
        logic [3:0]  sh;
        logic        z;
        logic        d;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] man_in = 16'h0;
    logic [4:0]  exp_in = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] man_out;
    logic [4:0]  exp_out;
    logic [3:0]  shamt_out;
    logic        zero_out;
    logic        denorm_out;

    int   checks = 0;
    int   passes = 0;
    res_t sb[$];
    res_t got;
    res_t want;
    int   lat;

    fp_lnorm16 #(.EXP_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .man_in    (man_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .man_out   (man_out),
        .exp_out   (exp_out),
        .shamt_out (shamt_out),
        .zero_out  (zero_out),
        .denorm_out(denorm_out)
    );

    always #5 clk = ~clk;

    // Reference: shift one bit at a time while not normalised and exponent > 0.
    function automatic res_t model(logic [15:0] m, logic [4:0] e);
        res_t r;
        r.man = m; r.e = e; r.sh = 4'd0; r.z = (m == 16'h0); r.d = 1'b0;
        if (m == 16'h0) begin
            r.man = 16'h0; r.e = 5'd0;
            return r;
        end
        while (!r.man[15] && r.e != 5'd0) begin
            r.man = r.man << 1; r.e = r.e - 5'd1; r.sh = r.sh + 4'd1;
        end
        r.d = ~r.man[15];
        return r;
    endfunction

    function automatic res_t outs();
        res_t r;
        r.man = man_out; r.e = exp_out; r.sh = shamt_out; r.z = zero_out; r.d = denorm_out;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Drive one operand (expectation already pushed), wait bounded for out_valid,
    // capture outputs into got and pop the scoreboard into want. lat=-1 on timeout.
    task automatic run_op(input logic [15:0] m, input logic [4:0] e);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        in_valid = 1'b1; man_in = m; exp_in = e;
        tick();
        in_valid = 1'b0; man_in = 16'hDEAD; exp_in = 5'd9;
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        if (!out_valid) lat = -1;
        got = outs();
        want = (sb.size() > 0) ? sb.pop_front() : '0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL reset_hs: got %b want 10", {in_ready, out_valid});
        else passes++;
        checks++;
        if (outs() !== res_t'(0)) $display("FAIL reset_outs: got %h want 0", outs());
        else passes++;
    endtask

    task automatic test_spec_vectors();
        logic [15:0] vm [5] = '{16'h0123, 16'h0010, 16'h0000, 16'h8001, 16'h0001};
        logic [4:0]  ve [5] = '{5'd20, 5'd3, 5'd17, 5'd5, 5'd31};
        res_t        vr [5] = '{
            '{16'h9180, 5'd13, 4'd7,  1'b0, 1'b0},
            '{16'h0080, 5'd0,  4'd3,  1'b0, 1'b1},
            '{16'h0000, 5'd0,  4'd0,  1'b1, 1'b0},
            '{16'h8001, 5'd5,  4'd0,  1'b0, 1'b0},
            '{16'h8000, 5'd16, 4'd15, 1'b0, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(vr[i]);
            run_op(vm[i], ve[i]);
            checks++;
            if (lat !== 4) $display("FAIL spec%0d_latency: got %0d want 4", i, lat);
            else passes++;
            checks++;
            if (got !== want) $display("FAIL spec%0d_result: got %h want %h", i, got, want);
            else passes++;
            release_out();
        end
    endtask

    task automatic test_backpressure();
        res_t held;
        sb.push_back(model(16'h00F0, 5'd9));
        run_op(16'h00F0, 5'd9);
        checks++;
        if (got !== want) $display("FAIL bp_result: got %h want %h", got, want);
        else passes++;
        held = got;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; man_in = 16'h0001; exp_in = 5'd31;
            tick();
            checks++;
            if ({out_valid, in_ready, outs()} !== {2'b10, held})
                $display("FAIL bp_hold%0d: got %b_%b_%h want 1_0_%h", i, out_valid, in_ready, outs(), held);
            else passes++;
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release: got %b want 01", {out_valid, in_ready});
        else passes++;
        tick(); tick(); tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_no_spurious: got %b want 01", {out_valid, in_ready});
        else passes++;
    endtask

    task automatic test_reset_midop();
        in_valid = 1'b1; man_in = 16'h0042; exp_in = 5'd20;
        tick();                      // accepted, now in S8
        in_valid = 1'b0;
        tick();                      // now in S4
        checks++;
        if ({out_valid, in_ready} !== 2'b00) $display("FAIL rstmid_busy: got %b want 00", {out_valid, in_ready});
        else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, outs()} !== {2'b01, res_t'(0)})
            $display("FAIL rstmid_state: got %b_%b_%h want 0_1_0", out_valid, in_ready, outs());
        else passes++;
        sb.push_back(model(16'h0300, 5'd30));
        run_op(16'h0300, 5'd30);
        checks++;
        if (lat !== 4) $display("FAIL rstmid_latency: got %0d want 4", lat);
        else passes++;
        checks++;
        if (got !== want) $display("FAIL rstmid_result: got %h want %h", got, want);
        else passes++;
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [15:0] m;
        logic [4:0]  e;
        for (int i = 0; i < 24; i++) begin
            m = 16'($urandom) >> $urandom_range(0, 16);
            e = 5'($urandom);
            if (i == 0) begin m = 16'h0007; e = 5'd0; end
            if (i == 1) begin m = 16'h00FF; e = 5'd8; end
            sb.push_back(model(m, e));
            run_op(m, e);
            checks++;
            if (lat !== 4) $display("FAIL b2b%0d_latency: got %0d want 4", i, lat);
            else passes++;
            checks++;
            if (got !== want) $display("FAIL b2b%0d_result m=%h e=%0d: got %h want %h", i, m, e, got, want);
            else passes++;
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
